// File: rtl/ctrl_handoff_arb_if.sv
// Control-bus bundle exchanged between the main/extension FSMs and the handoff arbiter.
// master: the FSM side that drives requests and control words; slave: the arbiter.
interface ctrl_handoff_arb_if;
  logic [18:0] i_main_ctrl;
  logic [18:0] i_ext_ctrl;
  logic [7:0]  i_main_state;
  logic [7:0]  i_ext_state;
  logic        i_main_handoff;
  logic        i_ext_done;
  logic        i_tmo_clr;
  logic [18:0] o_ctrl;
  logic [7:0]  o_c_state;
  logic        o_main_rst_n;
  logic        o_ext_rst_n;
  logic        o_owner_ext;
  logic        o_timeout;
  logic [7:0]  o_handoff_cnt;

  modport master (
    output i_main_ctrl, i_ext_ctrl, i_main_state, i_ext_state,
    output i_main_handoff, i_ext_done, i_tmo_clr,
    input  o_ctrl, o_c_state, o_main_rst_n, o_ext_rst_n,
    input  o_owner_ext, o_timeout, o_handoff_cnt
  );

  modport slave (
    input  i_main_ctrl, i_ext_ctrl, i_main_state, i_ext_state,
    input  i_main_handoff, i_ext_done, i_tmo_clr,
    output o_ctrl, o_c_state, o_main_rst_n, o_ext_rst_n,
    output o_owner_ext, o_timeout, o_handoff_cnt
  );
endinterface

// File: rtl/ctrl_handoff_arb.sv
// Arbitrates ownership of the datapath control bus between the main FSM and an
// extension FSM, with a one-cycle safe slot on entry and exit plus a watchdog.
module ctrl_handoff_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ctrl_handoff_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_MAIN      = 2'd0,
    S_EXT_START = 2'd1,
    S_EXT       = 2'd2,
    S_RETURN    = 2'd3
  } state_t;

  localparam logic [7:0]  WDOG_LAST = 8'(TIMEOUT - 32'd1);
  localparam logic [18:0] CTRL_SAFE = 19'h00000;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  wdog_r;
  logic        timeout_r;
  logic [7:0]  cnt_r;
  logic        tmo_set_s;

  logic        main_rst_n_s;
  logic        ext_rst_n_s;
  logic        owner_ext_s;
  logic [18:0] ctrl_s;
  logic [7:0]  c_state_s;

  // Next-state selection; done beats the watchdog when both fire together.
  always_comb begin
    state_nxt_s = state_r;
    tmo_set_s   = 1'b0;
    case (state_r)
      S_MAIN: begin
        if (bus.i_main_handoff) state_nxt_s = S_EXT_START;
        else                    state_nxt_s = S_MAIN;
      end
      S_EXT_START: state_nxt_s = S_EXT;
      S_EXT: begin
        if (bus.i_ext_done) begin
          state_nxt_s = S_RETURN;
        end else if (wdog_r == WDOG_LAST) begin
          state_nxt_s = S_RETURN;
          tmo_set_s   = 1'b1;
        end else begin
          state_nxt_s = S_EXT;
        end
      end
      S_RETURN: state_nxt_s = S_MAIN;
      default:  state_nxt_s = S_MAIN;
    endcase
  end

  // Ownership state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_r <= S_MAIN;
    else          state_r <= state_nxt_s;
  end

  // Watchdog: zeroed in the start slot, counts extension-owned cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wdog_r <= 8'd0;
    end else begin
      case (state_r)
        S_EXT_START: wdog_r <= 8'd0;
        S_EXT:       wdog_r <= wdog_r + 8'd1;
        default:     wdog_r <= wdog_r;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           timeout_r <= 1'b0;
    else if (tmo_set_s)     timeout_r <= 1'b1;
    else if (bus.i_tmo_clr) timeout_r <= 1'b0;
    else                    timeout_r <= timeout_r;
  end

  // Completed-return counter, wraps naturally at 8 bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 cnt_r <= 8'd0;
    else if (state_r == S_RETURN) cnt_r <= cnt_r + 8'd1;
    else                          cnt_r <= cnt_r;
  end

  // Sub-FSM resets and owner flag depend on the state register alone.
  always_comb begin
    main_rst_n_s = 1'b1;
    ext_rst_n_s  = 1'b0;
    owner_ext_s  = 1'b0;
    case (state_r)
      S_MAIN: begin
        main_rst_n_s = 1'b1;
        ext_rst_n_s  = 1'b0;
      end
      S_EXT_START: begin
        main_rst_n_s = 1'b1;
        ext_rst_n_s  = 1'b1;
      end
      S_EXT: begin
        main_rst_n_s = 1'b1;
        ext_rst_n_s  = 1'b1;
        owner_ext_s  = 1'b1;
      end
      S_RETURN: begin
        main_rst_n_s = 1'b0;
        ext_rst_n_s  = 1'b0;
      end
      default: begin
        main_rst_n_s = 1'b0;
        ext_rst_n_s  = 1'b0;
      end
    endcase
  end

  // Control word and state-code mux; transition slots drive the safe all-zero word.
  always_comb begin
    ctrl_s    = CTRL_SAFE;
    c_state_s = 8'd0;
    case (state_r)
      S_MAIN: begin
        ctrl_s    = bus.i_main_ctrl;
        c_state_s = bus.i_main_state;
      end
      S_EXT_START: begin
        ctrl_s    = CTRL_SAFE;
        c_state_s = bus.i_main_state;
      end
      S_EXT: begin
        ctrl_s    = bus.i_ext_ctrl;
        c_state_s = bus.i_ext_state;
      end
      S_RETURN: begin
        ctrl_s    = CTRL_SAFE;
        c_state_s = 8'd0;
      end
      default: begin
        ctrl_s    = CTRL_SAFE;
        c_state_s = 8'd0;
      end
    endcase
  end

  // Holding reset forces every owner-facing output to its quiescent value.
  assign bus.o_main_rst_n  = main_rst_n_s & i_rst_n;
  assign bus.o_ext_rst_n   = ext_rst_n_s  & i_rst_n;
  assign bus.o_owner_ext   = owner_ext_s  & i_rst_n;
  assign bus.o_ctrl        = i_rst_n ? ctrl_s    : CTRL_SAFE;
  assign bus.o_c_state     = i_rst_n ? c_state_s : 8'd0;
  assign bus.o_timeout     = timeout_r;
  assign bus.o_handoff_cnt = cnt_r;

endmodule
